tt_um_draft_pattern_seq: RTL and testbench
==========================================

// Module: tt_um_draft_pattern_seq
// PURPOSE
//  Parametrised successor of the constant-pattern top: a loadable pattern sequencer on uo_out.
//  - Patterns are written from uio_in into a DEPTH-entry store.
//  - Modes: idle (fixed pattern), forward run, ping-pong or hold.
//  - A PRESCALE-cycle step timer advances the sequence.
//  - Sits directly at the TinyTapeout pin boundary as the user top.
// PARAMETERS
//  WIDTH          8      pattern width in bits, 1..8; uo_out bits above WIDTH driven 0
//  DEPTH          8      pattern store entries, power of two, >=2
//  PRESCALE       1000   clock cycles per sequence step, >=1
//  RESET_PATTERN  8'h50  pattern shown in idle, after reset and when store empty
// PORTS
//  clk      in   1  clock
//  rst_n    in   1  asynchronous active-low reset
//  ena      in   1  powered indicator, ignored
//  ui_in    in   8  [7] load strobe, [6:5] mode, [4] clear, [3:0] unused
//  uio_in   in   8  pattern data, [WIDTH-1:0] used
//  uo_out   out  8  registered current pattern
//  uio_out  out  8  constant 0
//  uio_oe   out  8  constant 0 (all uio pins inputs)
// BEHAVIOUR
//  Clock/reset: one clock, clk. Reset is rst_n, asynchronous assert, active-low.
//  Reset values:
//  - uo_out = RESET_PATTERN; count, wr_ptr, idx and prescaler = 0; dir = up.
//  - All store entries = 0. Load-edge register = 0.
//  Load:
//  - Rising edge of ui_in[7] (registered previous value) gives a 1-cycle strobe.
//  - On strobe: mem[wr_ptr] <= uio_in[WIDTH-1:0]; wr_ptr++; count++.
//  - count saturates at DEPTH (full); strobes while full are dropped.
//  - Loads are accepted in every mode.
//  Clear: while ui_in[4]=1, count, wr_ptr, idx and prescaler are held at 0 and dir = up; store contents kept.
//  - Clear beats a load strobe in the same cycle (the load is dropped).
//  Mode ui_in[6:5]:
//  - 00 IDLE: idx, prescaler and dir held at reset values; display = RESET_PATTERN.
//  - 01 RUN: prescaler counts 0..PRESCALE-1. At terminal it wraps to 0 and idx steps:
//    idx = (idx==count-1) ? 0 : idx+1.
//  - 10 PINGPONG: same step timing. dir up: idx+1; on reaching count-1, dir flips to down. dir down: idx-1; on reaching 0, dir flips to up.
//    Endpoints are shown for one step only, not repeated.
//  - 11 HOLD: idx, prescaler and dir frozen. Leaving HOLD for RUN/PINGPONG resumes from the frozen state.
//  Empty store:
//  - count==0 in any mode: display = RESET_PATTERN; idx stays 0; steps ignored.
//  - count==1: idx stays 0.
//  Output timing:
//  - uo_out <= display, computed from state before the edge, so it is 1 cycle after an idx/mem/mode change.
//  - Display = mem[idx] outside IDLE/empty.
//  - Write to the displayed entry appears on uo_out 2 edges after the strobe edge.
//  Count shrink: if count drops (clear) with idx >= count, idx is forced to 0 with the clear.
//  Mode changes: mode is sampled every cycle, no synchronisation; the external source is clk-synchronous.
// CONFIGURATION
//  PATSEQ_PINGPONG_EN
//  - Defined: mode 10 is PINGPONG as above.
//  - Undefined: mode 10 behaves exactly as RUN; dir register and its logic are removed.
// TESTING (PRESCALE=4, WIDTH=8, DEPTH=4 unless stated)
//  1 Reset, mode 00 -> uo_out=8'h50, uio_out=0, uio_oe=0. Assert rst_n=0 mid-RUN -> uo_out=8'h50 with no clk edge.
//  2 Load 11,22,33 via three ui_in[7] pulses, mode 01 -> uo_out 11,22,33,11..., each held exactly 4 cycles.
//  3 Same data, mode 10 (PINGPONG_EN defined) -> 11,22,33,22,11,22. Without the macro -> 11,22,33,11.
//  4 Load 5 entries AA,BB,CC,DD,EE -> 5th dropped; RUN shows AA,BB,CC,DD cycling.
//  5 RUN at idx=2, switch to 11 for 10 cycles, back to 01 -> idx 2 held; next step after remaining prescale.
//  6 Clear pulse with a load strobe in the same cycle -> count=0, uo_out=8'h50; the next load goes to entry 0.

Source files
------------

// File: rtl/tt_um_draft_pattern_seq_if.sv
// Pin bundle for tt_um_draft_pattern_seq: the TinyTapeout user pins other than clk/rst_n.
// master drives the inputs (harness or bench), slave is the user design.
interface tt_um_draft_pattern_seq_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_draft_pattern_seq.sv
// Loadable pattern sequencer on uo_out: idle / run / ping-pong / hold, stepped by a prescaler.
// Optional feature macro: PATSEQ_PINGPONG_EN (undefined: mode 10 behaves as run, no dir register).
module tt_um_draft_pattern_seq #(
   parameter int          WIDTH         = 8,
   parameter int          DEPTH         = 8,
   parameter int          PRESCALE      = 1000,
   parameter logic [7:0]  RESET_PATTERN = 8'h50
) (
   input  logic                       clk,
   input  logic                       rst_n,
   tt_um_draft_pattern_seq_if.slave   pins
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = $clog2(PRESCALE + 1);

   // Bits at or above WIDTH never reach uo_out, including for the idle pattern.
   localparam logic [7:0] OUT_MASK   = 8'((9'h1 << WIDTH) - 9'h1);
   localparam logic [7:0] IDLE_SHOWN = RESET_PATTERN & OUT_MASK;

   typedef enum logic [1:0] {
      MODE_IDLE     = 2'b00,
      MODE_RUN      = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    idx;
   logic [PW-1:0]    presc;
   logic             load_q;
   logic [7:0]       uo_q;

   mode_e            mode;
   logic             load_stb;
   logic             clear;
   logic             full;
   logic             terminal;
   logic [AW-1:0]    last_idx;
   logic [AW-1:0]    run_idx;
   logic [7:0]       display;
   logic [WIDTH-1:0] wdata;

   assign mode     = mode_e'(pins.ui_in[6:5]);
   assign clear    = pins.ui_in[4];
   assign load_stb = pins.ui_in[7] & ~load_q;
   assign wdata    = pins.uio_in[WIDTH-1:0];
   assign full     = (count == CW'(DEPTH));
   assign terminal = (presc == PW'(PRESCALE - 1));
   // Only meaningful when count != 0; steps are suppressed for an empty store.
   assign last_idx = AW'(count - CW'(1));
   assign run_idx  = (idx == last_idx) ? '0 : idx + AW'(1);

`ifdef PATSEQ_PINGPONG_EN
   logic          dir_down;
   logic          go_up;
   logic [AW-1:0] pp_idx;
   logic          pp_dir_down;

   // Direction flips on arrival at an endpoint, so each endpoint is shown for one step.
   // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
   always_comb begin
      go_up       = 1'b1;
      pp_idx      = '0;
      pp_dir_down = 1'b0;
      if (count != CW'(1)) begin
         go_up       = dir_down ? (idx == '0) : (idx != last_idx);
         pp_idx      = go_up ? idx + AW'(1) : idx - AW'(1);
         pp_dir_down = go_up ? (pp_idx == last_idx) : (pp_idx != '0);
      end
   end
`endif

   always_comb begin
      display = IDLE_SHOWN;
      if (mode != MODE_IDLE && count != '0) begin
         display = 8'(mem[idx]);
      end
   end

   // NOTE: the pattern store is reset too, so a cleared-then-reloaded store never exposes X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (!clear && load_stb && !full) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every term sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q   <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         idx      <= '0;
         presc    <= '0;
         uo_q     <= IDLE_SHOWN;
`ifdef PATSEQ_PINGPONG_EN
         dir_down <= 1'b0;
`endif
      end else begin
         load_q <= pins.ui_in[7];
         uo_q   <= display;
         if (clear) begin
            count    <= '0;
            wr_ptr   <= '0;
            idx      <= '0;
            presc    <= '0;
`ifdef PATSEQ_PINGPONG_EN
            dir_down <= 1'b0;
`endif
         end else begin
            if (load_stb && !full) begin
               wr_ptr <= wr_ptr + AW'(1);
               count  <= count + CW'(1);
            end
            case (mode)
               MODE_IDLE: begin
                  idx      <= '0;
                  presc    <= '0;
`ifdef PATSEQ_PINGPONG_EN
                  dir_down <= 1'b0;
`endif
               end
               MODE_HOLD: begin
               end
               default: begin
                  if (terminal) begin
                     presc <= '0;
                     if (count != '0) begin
`ifdef PATSEQ_PINGPONG_EN
                        if (mode == MODE_PINGPONG) begin
                           idx      <= pp_idx;
                           dir_down <= pp_dir_down;
                        end else begin
                           idx <= run_idx;
                        end
`else
                        idx <= run_idx;
`endif
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign pins.uo_out  = uo_q;
   assign pins.uio_out = 8'h00;
   assign pins.uio_oe  = 8'h00;

   logic unused_ok;
   assign unused_ok = &{1'b0, pins.ena, pins.ui_in[3:0], pins.uio_in};

endmodule

// File: tb/tb_tt_um_draft_pattern_seq.sv
// Randomised scoreboard bench for tt_um_draft_pattern_seq (PRESCALE=4, WIDTH=8, DEPTH=4).
// Build with PATSEQ_PINGPONG_EN defined or not; the reference model follows the same macro.
module tb_tt_um_draft_pattern_seq;

   localparam int         WIDTH    = 8;
   localparam int         DEPTH    = 4;
   localparam int         PRESCALE = 4;
   localparam logic [7:0] RST_PAT  = 8'h50;

   logic clk = 1'b0;
   logic rst_n;

   tt_um_draft_pattern_seq_if pins ();

   tt_um_draft_pattern_seq #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .PRESCALE      (PRESCALE),
      .RESET_PATTERN (RST_PAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pins  (pins.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q [$];

   // Reference state: the specification's own variables, kept as plain integers.
   logic [7:0] m_mem [DEPTH];
   int         m_count;
   int         m_wr;
   int         m_idx;
   int         m_phase;
   bit         m_down;
   bit         m_ldq;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_count = 0;
      m_wr    = 0;
      m_idx   = 0;
      m_phase = 0;
      m_down  = 1'b0;
      m_ldq   = 1'b0;
   endtask

   function automatic logic [7:0] model_display(input logic [1:0] mode);
      if (mode == 2'b00 || m_count == 0) return RST_PAT;
      return m_mem[m_idx];
   endfunction

   task automatic model_step(input logic [1:0] mode);
      bit pingpong;
`ifdef PATSEQ_PINGPONG_EN
      pingpong = (mode == 2'b10);
`else
      pingpong = 1'b0;
`endif
      if (m_phase != PRESCALE - 1) begin
         m_phase++;
         return;
      end
      m_phase = 0;
      if (m_count == 0) return;
      if (!pingpong) begin
         m_idx = (m_idx + 1) % m_count;
      end else if (m_count == 1) begin
         m_idx  = 0;
         m_down = 1'b0;
      end else begin
         if (!m_down) m_idx = (m_idx < m_count - 1) ? m_idx + 1 : m_idx - 1;
         else         m_idx = (m_idx > 0) ? m_idx - 1 : m_idx + 1;
         if (m_idx == m_count - 1) m_down = 1'b1;
         else if (m_idx == 0)      m_down = 1'b0;
      end
   endtask

   task automatic model_update(input bit ld, input logic [1:0] mode, input bit clr,
                               input logic [7:0] data);
      bit stb;
      stb   = ld && !m_ldq;
      m_ldq = ld;
      if (clr) begin
         m_count = 0;
         m_wr    = 0;
         m_idx   = 0;
         m_phase = 0;
         m_down  = 1'b0;
         return;
      end
      // Stepping uses the pre-edge count, so it is evaluated before the load lands.
      case (mode)
         2'b00: begin
            m_idx   = 0;
            m_phase = 0;
            m_down  = 1'b0;
         end
         2'b11: ;
         default: model_step(mode);
      endcase
      if (stb && m_count < DEPTH) begin
         m_mem[m_wr] = data;
         m_wr        = (m_wr + 1) % DEPTH;
         m_count++;
      end
   endtask

   task automatic drive(input bit ld, input logic [1:0] mode, input bit clr,
                        input logic [7:0] data);
      logic [7:0] e;
      @(negedge clk);
      pins.ui_in  = {ld, mode, clr, 4'h0};
      pins.uio_in = data;
      e = model_display(mode);
      model_update(ld, mode, clr, data);
      exp_q.push_back(e);
   endtask

   task automatic load(input logic [7:0] data, input logic [1:0] mode);
      drive(1'b1, mode, 1'b0, data);
      drive(1'b0, mode, 1'b0, data);
   endtask

   // Monitor: the design presents a new pattern every cycle; compare after each edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("uo_out", pins.uo_out, e);
            check("uio_out", pins.uio_out, 8'h00);
            check("uio_oe", pins.uio_oe, 8'h00);
         end
      end
   end

   initial begin
      pins.ena    = 1'b1;
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'h00;
      rst_n       = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check("reset_uo_out", pins.uo_out, RST_PAT);
      check("reset_uio_out", pins.uio_out, 8'h00);
      check("reset_uio_oe", pins.uio_oe, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Load three, then run and ping-pong.
      drive(1'b0, 2'b00, 1'b0, 8'h00);
      load(8'h11, 2'b00);
      load(8'h22, 2'b00);
      load(8'h33, 2'b00);
      repeat (26) drive(1'b0, 2'b01, 1'b0, 8'h00);
      repeat (2)  drive(1'b0, 2'b00, 1'b0, 8'h00);
      repeat (26) drive(1'b0, 2'b10, 1'b0, 8'h00);

      // Overfill: the fifth load is dropped.
      drive(1'b0, 2'b00, 1'b1, 8'h00);
      load(8'hAA, 2'b00);
      load(8'hBB, 2'b00);
      load(8'hCC, 2'b00);
      load(8'hDD, 2'b00);
      load(8'hEE, 2'b00);
      repeat (20) drive(1'b0, 2'b01, 1'b0, 8'h00);

      // Hold mid-sequence, then resume.
      drive(1'b0, 2'b00, 1'b0, 8'h00);
      repeat (9)  drive(1'b0, 2'b01, 1'b0, 8'h00);
      repeat (10) drive(1'b0, 2'b11, 1'b0, 8'h00);
      repeat (10) drive(1'b0, 2'b01, 1'b0, 8'h00);

      // Clear wins over a simultaneous load strobe; next load lands in entry 0.
      drive(1'b1, 2'b01, 1'b1, 8'h77);
      repeat (3) drive(1'b0, 2'b01, 1'b0, 8'h00);
      load(8'h5A, 2'b01);
      repeat (8) drive(1'b0, 2'b01, 1'b0, 8'h00);

      // Randomised traffic: modes held in bursts, frequent load edges, rare clears.
      begin
         logic [1:0] mode;
         mode = 2'b01;
         for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) mode = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), mode, ($urandom_range(0, 59) == 0),
                  8'($urandom));
         end
      end

      // Asynchronous reset while running shows the reset pattern before any edge.
      drive(1'b0, 2'b00, 1'b1, 8'h00);
      load(8'h81, 2'b00);
      load(8'h42, 2'b00);
      load(8'h24, 2'b00);
      repeat (6) drive(1'b0, 2'b01, 1'b0, 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_uo_out", pins.uo_out, RST_PAT);
      pins.ui_in = 8'h00;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      load(8'h3C, 2'b00);
      load(8'hC3, 2'b00);
      repeat (12) drive(1'b0, 2'b10, 1'b0, 8'h00);

      repeat (2) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected values never compared", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
